// File: rtl/decode_execute_reg.sv
// rtl/decode_execute_reg.sv - ID/EX pipeline register with load-use bubbles and forwarding selects
// Holds the Decode->Execute boundary state; flush/load-use write bubbles, stall holds.
module decode_execute_reg #(
   parameter int DW     = 32,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_d,
   input  logic [DW-1:0]     rd1_d,
   input  logic [DW-1:0]     rd2_d,
   input  logic [DW-1:0]     ext_imm_d,
   input  logic [3:0]        ra1_d,
   input  logic [3:0]        ra2_d,
   input  logic [3:0]        wa3_d,
   input  logic              reg_write_d,
   input  logic              mem_to_reg_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic              stall_e,
   input  logic              flush_e,
   input  logic [3:0]        wa3_m,
   input  logic [3:0]        wa3_w,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   output logic [DW-1:0]     rd1_e,
   output logic [DW-1:0]     rd2_e,
   output logic [DW-1:0]     ext_imm_e,
   output logic [3:0]        ra1_e,
   output logic [3:0]        ra2_e,
   output logic [3:0]        wa3_e,
   output logic              reg_write_e,
   output logic              mem_to_reg_e,
   output logic              valid_e,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic              load_use_stall,
   output logic [1:0]        fwd_a_e,
   output logic [1:0]        fwd_b_e,
   output logic [CNT_W-1:0]  bubble_count
);

   localparam logic [3:0]       PC_REG  = 4'hF;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic write_bubble;
   logic bubble_event;

   // R15 reads come from the PC path, so a load into R15 never needs a bubble.
   assign load_use_stall = valid_e & reg_write_e & mem_to_reg_e & valid_d &
                           (wa3_e != PC_REG) &
                           ((wa3_e == ra1_d) | (wa3_e == ra2_d));

   assign write_bubble = flush_e | (~stall_e & load_use_stall);
   assign bubble_event = write_bubble;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd1_e        <= '0;
         rd2_e        <= '0;
         ext_imm_e    <= '0;
         ra1_e        <= '0;
         ra2_e        <= '0;
         wa3_e        <= '0;
         reg_write_e  <= 1'b0;
         mem_to_reg_e <= 1'b0;
         valid_e      <= 1'b0;
         ctrl_e       <= '0;
      end else if (write_bubble) begin
         rd1_e        <= '0;
         rd2_e        <= '0;
         ext_imm_e    <= '0;
         ra1_e        <= '0;
         ra2_e        <= '0;
         wa3_e        <= '0;
         reg_write_e  <= 1'b0;
         mem_to_reg_e <= 1'b0;
         valid_e      <= 1'b0;
         ctrl_e       <= '0;
      end else if (!stall_e) begin
         rd1_e        <= rd1_d;
         rd2_e        <= rd2_d;
         ext_imm_e    <= ext_imm_d;
         ra1_e        <= ra1_d;
         ra2_e        <= ra2_d;
         wa3_e        <= wa3_d;
         // An empty Decode slot must not carry side-effecting control into E.
         reg_write_e  <= reg_write_d & valid_d;
         mem_to_reg_e <= mem_to_reg_d & valid_d;
         valid_e      <= valid_d;
         ctrl_e       <= valid_d ? ctrl_d : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bubble_count <= '0;
      end else if (bubble_event && bubble_count != CNT_MAX) begin
         bubble_count <= bubble_count + 1'b1;
      end
   end

   // MEM holds the younger result, so it takes precedence over WB.
   function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
      logic [1:0] sel;
      sel = 2'b00;
      if (valid_e && ra != PC_REG) begin
         if (reg_write_m && wa3_m == ra)
            sel = 2'b10;
         else if (reg_write_w && wa3_w == ra)
            sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a_e = fwd_sel(ra1_e);
      fwd_b_e = fwd_sel(ra2_e);
   end

endmodule
